// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD/LCM datapath: state encoding and default widths.
package gcd_pkg;

  localparam int unsigned LCM_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(LCM_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } lcm_state_e;

endpackage

// File: rtl/lcm_restoring_div.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// The *_c outputs expose the result of the step executing this cycle.
module lcm_restoring_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic             q_bit;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    rem_sh      = {rem_q, dvd_q[WIDTH-1]};
    q_bit       = (rem_sh >= {1'b0, dvs_q});
    remainder_c = q_bit ? WIDTH'(rem_sh - {1'b0, dvs_q}) : WIDTH'(rem_sh);
    quotient_c  = {quo_q[WIDTH-2:0], q_bit};
    done_c      = busy && (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= remainder_c;
      quo_q <= quotient_c;
      cnt_q <= cnt_q + CW'(1);
      busy  <= !done_c;
    end
  end

endmodule

// File: rtl/lcm_calc.sv
// LCM = (A / GCD) * B using a sequential divider and a shift-add multiplier,
// with valid/ready handshakes and an error flag for an inconsistent GCD.
module lcm_calc
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = LCM_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   gcd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] lcm_out,
  output logic               div_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = 2 * WIDTH;

  lcm_state_e state_q, state_d;

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mq_q;
  logic [RW-1:0]    bsh_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    acc_nxt_c;
  logic [CW-1:0]    mcnt_q;

  logic             div_start_c;
  logic             div_busy;
  logic             div_done_c;
  logic [WIDTH-1:0] div_quot_c;
  logic [WIDTH-1:0] div_rem_c;

  logic             load_op;
  logic             mul_load;
  logic             mul_step;
  logic             res_we;
  logic [RW-1:0]    res_lcm;
  logic             res_err;

  lcm_restoring_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start_c),
    .dividend    (a_in),
    .divisor     (gcd_in),
    .busy        (div_busy),
    .done_c      (div_done_c),
    .quotient_c  (div_quot_c),
    .remainder_c (div_rem_c)
  );

  assign acc_nxt_c = acc_q + (mq_q[0] ? bsh_q : RW'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control; results are only produced on entry to DONE.
  always_comb begin
    state_d     = state_q;
    load_op     = 1'b0;
    div_start_c = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    res_we      = 1'b0;
    res_lcm     = '0;
    res_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_op = 1'b1;
          if (gcd_in == '0) begin
            state_d = DONE;
            res_we  = 1'b1;
            res_err = 1'b1;
          end else begin
            div_start_c = 1'b1;
            state_d     = DIV;
          end
        end
      end
      DIV: begin
        if (div_busy && div_done_c) begin
          if (div_rem_c != '0) begin
            state_d = DONE;
            res_we  = 1'b1;
            res_err = 1'b1;
          end else begin
            state_d  = MUL;
            mul_load = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mcnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          res_we  = 1'b1;
          res_lcm = acc_nxt_c;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add multiplier: quotient consumed LSB first, B shifted left each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      mq_q   <= '0;
      bsh_q  <= '0;
      acc_q  <= '0;
      mcnt_q <= '0;
    end else begin
      if (load_op) b_q <= b_in;
      if (mul_load) begin
        mq_q   <= div_quot_c;
        bsh_q  <= RW'(b_q);
        acc_q  <= '0;
        mcnt_q <= '0;
      end else if (mul_step) begin
        mq_q   <= mq_q >> 1;
        bsh_q  <= bsh_q << 1;
        acc_q  <= acc_nxt_c;
        mcnt_q <= mcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lcm_out   <= '0;
      div_err   <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (res_we) begin
        lcm_out <= res_lcm;
        div_err <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_lcm_calc.sv
// Directed bench for lcm_calc with an expected-result queue and latency checks.
module tb_lcm_calc;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   gcd_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] lcm_out;
  logic           div_err;

  typedef struct packed {
    logic [15:0] lcm;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  lcm_calc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .gcd_in    (gcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lcm_out   (lcm_out),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned gcd_f(input int unsigned x, input int unsigned y);
    int unsigned p = x;
    int unsigned q = y;
    while (q != 0) begin
      int unsigned t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned g);
    exp_t e;
    if (g == 0) begin
      e.lcm = 16'd0; e.err = 1'b1; e.lat = 8'd0;
    end else if ((a % g) != 0) begin
      e.lcm = 16'd0; e.err = 1'b1; e.lat = 8'(W);
    end else begin
      e.lcm = 16'((a / g) * b); e.err = 1'b0; e.lat = 8'(2 * W);
    end
    return e;
  endfunction

  // Called one time unit after an edge; returns one time unit after the accepting edge.
  task automatic send(input int unsigned a, input int unsigned b, input int unsigned g, input bit push);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a_in = W'(a); b_in = W'(b); gcd_in = W'(g);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back(model(a, b, g));
  endtask

  task automatic collect(input int unsigned hold);
    int unsigned    cyc = 0;
    exp_t           e;
    logic [2*W-1:0] l0;
    logic           e0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("lcm_out", 32'(lcm_out), 32'(e.lcm));
    check("div_err", 32'(div_err), 32'(e.err));
    check("latency", cyc, 32'(e.lat));
    check("in_ready_while_done", 32'(in_ready), 32'd0);
    l0 = lcm_out;
    e0 = div_err;
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_lcm", 32'(lcm_out), 32'(l0));
      check("hold_err", 32'(div_err), 32'(e0));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_dropped", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; gcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_lcm", 32'(lcm_out), 32'd0);
    check("rst_err", 32'(div_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(12, 18, 6, 1);   collect(0);
    send(255, 254, 1, 1); collect(0);
    send(7, 3, 0, 1);     collect(0);
    send(12, 18, 5, 1);   collect(0);
    send(0, 9, 9, 1);     collect(0);
    send(10, 0, 5, 1);    collect(0);
    send(255, 255, 255, 1); collect(0);

    // Backpressure: result must sit untouched until out_ready.
    send(21, 6, 3, 1);    collect(5);
    send(8, 12, 4, 1);    collect(0);

    // Reset during the divide phase: no output for the aborted pair.
    send(12, 18, 6, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_lcm", 32'(lcm_out), 32'd0);
    check("midrst_err", 32'(div_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_output", 32'(out_valid), 32'd0);
    send(4, 6, 2, 1);     collect(0);

    // Random consistent pairs with the true GCD.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(1, 255);
      rb = $urandom_range(0, 255);
      send(ra, rb, gcd_f(ra, rb), 1);
      collect(i % 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
